pulse_stretch: RTL and testbench

//  Output-side counterpart of our input debouncer: turns single-cycle (or level) events into

---
 rtl/pulse_stretch_pkg.sv | 22 ++
 rtl/pulse_stretch_rise_detect.sv | 27 ++
 rtl/pulse_stretch.sv | 148 ++++++++++++++
 tb/tb_pulse_stretch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and elaboration-time helpers for the LED pulse stretcher.
// Optional queueing is selected in pulse_stretch with `PULSE_STRETCH_QUEUE_EN.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } ps_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 64-bit intermediate: ms * Hz overflows 32 bits at realistic clock rates.
  function automatic int ms_to_cycles(input int ms, input int freq_hz);
    longint cycles;
    cycles = longint'(ms) * longint'(freq_hz) / 64'sd1000;
    return int'(cycles);
  endfunction

endpackage

// File: rtl/pulse_stretch_rise_detect.sv
// Rising-edge detector: one registered copy of d, rise = d & ~d_q.
// A level held high produces exactly one rise pulse.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches event strobes into LED pulses with a minimum on-time and off-gap.
// Define PULSE_STRETCH_QUEUE_EN to queue events that arrive while a pulse is shown.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int CLKPD_NS   = 10,
  parameter int CLKFREQ    = 1_000_000_000 / CLKPD_NS,
  parameter int ON_MS      = 100,
  parameter int OFF_MS     = 50,
  parameter int ON_CYCLES  = ms_to_cycles(ON_MS, CLKFREQ),
  parameter int OFF_CYCLES = ms_to_cycles(OFF_MS, CLKFREQ),
  parameter int PEND_MAX   = 7,
  parameter int CTRBITS    = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1),
  parameter int PENDBITS   = $clog2(PEND_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev,
  output logic                led,
  output logic                busy,
  output logic [PENDBITS-1:0] pending,
  output logic                ovf
);

  localparam logic [CTRBITS-1:0] ON_LAST  = CTRBITS'(ON_CYCLES - 1);
  localparam logic [CTRBITS-1:0] OFF_LAST = CTRBITS'(OFF_CYCLES - 1);

  logic               ev_rise;
  ps_state_t          state_q, state_d;
  logic [CTRBITS-1:0] timer_q, timer_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               extra_ev;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PENDBITS-1:0] PEND_FULL = PENDBITS'(PEND_MAX);
  logic [PENDBITS-1:0] pending_q, pending_d;
`endif

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst  (rst),
    .d    (ev),
    .rise (ev_rise)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    ovf_d    = ovf_q;
    extra_ev = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
    pending_d = pending_q;
`endif

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (ev_rise) begin
          state_d = ON;
        end
      end
      ON: begin
        extra_ev = ev_rise;
        if (timer_q == ON_LAST) begin
          state_d = GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          // An event landing on the last gap cycle is shown immediately, so the
          // queue depth is left untouched (take one, add one).
          if (ev_rise) begin
            state_d = ON;
          end
`ifdef PULSE_STRETCH_QUEUE_EN
          else if (pending_q != '0) begin
            state_d   = ON;
            pending_d = pending_q - 1'b1;
          end
`endif
          else begin
            state_d = IDLE;
          end
        end else begin
          extra_ev = ev_rise;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (extra_ev) begin
`ifdef PULSE_STRETCH_QUEUE_EN
      if (pending_q == PEND_FULL) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
`else
      ovf_d = 1'b1;
`endif
    end

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PULSE_STRETCH_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = '0;
`endif

  assign led  = led_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed, table-driven bench for pulse_stretch (ON=4, OFF=2, PEND_MAX=3).
// Expectations follow whichever PULSE_STRETCH_QUEUE_EN setting the build uses.
module tb_pulse_stretch;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int PMAX  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev  = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  always #5 clk = ~clk;

  pulse_stretch #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .PEND_MAX   (PMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev      (ev),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .ovf     (ovf)
  );

  // Each record: inputs driven before an edge, outputs expected just after it.
  typedef struct packed {
    logic       rst;
    logic       ev;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic r, input logic e, input logic l,
                              input logic b, input logic [1:0] p, input logic o);
    vec_t v;
    v = '{rst: r, ev: e, led: l, busy: b, pend: p, ovf: o};
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic r, input logic e, input logic l,
                                input logic b, input logic [1:0] p, input logic o);
    for (int k = 0; k < n; k++) add(r, e, l, b, p, o);
  endfunction

  task automatic check(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int gap;
    int n;

    // Reset state
    add_n(2, 1, 0, 0, 0, 0, 0);
    // Single 1-cycle event: 4 cycles on, 2 gap, then idle
    add(0, 1, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(2, 0, 0, 0, 0, 0, 0);
    // ev held high 20 cycles: one pulse only
    add(0, 1, 1, 1, 0, 0);
    add_n(3, 0, 1, 1, 1, 0, 0);
    add_n(2, 0, 1, 0, 1, 0, 0);
    add_n(14, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // Event on last gap cycle with nothing queued: straight back to ON
    add(0, 1, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
`ifdef PULSE_STRETCH_QUEUE_EN
    // Queue fills to 3, one event dropped (ovf), queue drains as back-to-back pulses
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 1, 2, 0);
    add(0, 0, 0, 1, 2, 0);
    add(0, 1, 1, 1, 2, 0);
    add(0, 0, 1, 1, 2, 0);
    add(0, 1, 1, 1, 3, 0);
    add(0, 0, 1, 1, 3, 0);
    add(0, 1, 0, 1, 3, 1);
    add(0, 0, 0, 1, 3, 1);
    add_n(4, 0, 0, 1, 1, 2, 1);
    add_n(2, 0, 0, 0, 1, 2, 1);
    add_n(4, 0, 0, 1, 1, 1, 1);
    add_n(2, 0, 0, 0, 1, 1, 1);
    add_n(4, 0, 0, 1, 1, 0, 1);
    add_n(2, 0, 0, 0, 1, 0, 1);
    add_n(2, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0);
    // Reset mid-ON with pending=2
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 1, 2, 0);
    add(0, 0, 0, 1, 2, 0);
    add(0, 1, 1, 1, 2, 0);
    add(0, 0, 1, 1, 2, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
`else
    // No queue: events during ON/GAP are dropped and set ovf, only one pulse
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add_n(2, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0);
    // Reset mid-ON
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      ev  = vecs[i].ev;
      step_clk();
      $display("step %0d rst=%b ev=%b led=%b busy=%b pending=%0d ovf=%b",
               i, rst, ev, led, busy, pending, ovf);
      check("led",     i, int'(led),     int'(vecs[i].led));
      check("busy",    i, int'(busy),    int'(vecs[i].busy));
      check("pending", i, int'(pending), int'(vecs[i].pend));
      check("ovf",     i, int'(ovf),     int'(vecs[i].ovf));
    end

    // Measured pulse width and gap for a single strobe, with a cycle budget
    rst = 1'b0;
    ev  = 1'b1;
    step_clk();
    ev  = 1'b0;
    hi  = 0;
    gap = 0;
    n   = 0;
    while (led && n < 40) begin
      hi++;
      step_clk();
      n++;
    end
    while (busy && n < 40) begin
      gap++;
      step_clk();
      n++;
    end
    $display("measure led_high=%0d gap=%0d cycles_used=%0d", hi, gap, n);
    check("within_budget", 0, int'(n < 40), 1);
    check("on_width",      0, hi,  ON_C);
    check("gap_width",     0, gap, OFF_C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
